pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Sequences the IF/ID/EX front end using the hazard flag from the hazard detector.
//  It holds the PC and IF/ID register and inserts NOP bubbles into ID/EX while a RAW hazard persists.
//  It flushes IF/ID on a taken branch or jump, and publishes the instruction actually issued to EX.
//  That issued instruction feeds the detector's history, so bubbles are seen as NOPs.
// PARAMETERS
//  DEPTH      3        max consecutive stall cycles for one instruction (writeback distance)
//  NOP_INSTR  16'h0000 encoding injected on bubble/flush
//  PERF_W     16       width of stall performance counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset; asynchronous, active-high
//  id_instr     in   16      instruction currently in ID
//  id_valid     in   1       id_instr is a real instruction
//  hazard       in   1       RAW hazard on id_instr (combinational, same cycle)
//  br_flush     in   1       taken branch/jump resolved in EX this cycle
//  pc_we        out  1       PC write enable (0 = hold)
//  ifid_we      out  1       IF/ID write enable (0 = hold)
//  ifid_flush   out  1       clear IF/ID to NOP_INSTR at next edge
//  idex_bubble  out  1       load NOP_INSTR into ID/EX at next edge
//  issue_instr  out  16      registered copy of instruction now in EX
//  stall_cnt    out  2       stall cycles spent on current ID instruction
//  stall_err    out  1       sticky: stall hit DEPTH and was force-released
//  perf_stalls  out  PERF_W  saturating count of hazard bubble cycles
// BEHAVIOUR
//  - Reset (async):
//    state=RUN, stall_cnt=0, stall_err=0, perf_stalls=0, issue_instr=NOP_INSTR.
//    With no inputs active, pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
//  - Control outputs are Mealy (state + inputs), with zero latency.
//    Registered outputs update on the clk edge.
//  - FSM states: RUN, STALL, FLUSH.
//  - Priority: br_flush > hazard in every state.
//  - br_flush=1 (any state):
//    pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
//    stall_cnt<=0; next state FLUSH; perf_stalls is not incremented.
//  - RUN, stall trigger:
//    Condition: hazard && id_valid && !br_flush.
//    Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
//    Updates: stall_cnt<=1, next STALL, perf_stalls++.
//  - RUN, otherwise: issue normally.
//  - STALL, continue: hazard && stall_cnt<DEPTH.
//    Stall outputs as above; stall_cnt++, perf_stalls++.
//  - STALL, release: !hazard.
//    Issue id_instr; stall_cnt<=0; next RUN.
//  - STALL, forced release: hazard && stall_cnt==DEPTH.
//    Issue anyway, set stall_err (sticky until rst), stall_cnt<=0, next RUN.
//  - FLUSH: exactly one cycle; hazard is masked (ID holds the flushed NOP); next RUN.
//  - issue_instr <= (idex_bubble || !id_valid) ? NOP_INSTR : id_instr, every edge.
//  - perf_stalls saturates at all-ones and never wraps.
//  - Reset mid-STALL or mid-FLUSH: immediate return to reset values; no partial issue.
// STRUCTURE
//  - Add to define.v: `NOP_INSTR and state encodings `SC_RUN=2'd0, `SC_STALL=2'd1, `SC_FLUSH=2'd2.
//  - One sub-module, sat_counter (PERF_W, inc, clr, q), instantiated for perf_stalls.
//  - FSM, stall_cnt and issue register live in this module.
// TESTING
//  1. Reset then idle, id_valid=1, hazard=0:
//     pc_we=ifid_we=1, bubble=0, issue_instr follows id_instr one cycle later.
//  2. hazard=1 for 2 cycles, then 0:
//     pc_we=0 for 2 cycles; two NOPs issued; stall_cnt 1,2,0; perf_stalls=2; id_instr issued on 3rd edge.
//  3. hazard held 5 cycles:
//     3 bubbles, then forced issue; stall_err=1 and stays 1.
//     A further hazard starts a new stall with stall_cnt=1.
//  4. br_flush=1 together with hazard=1 in RUN:
//     ifid_flush=1, bubble=1, pc_we=1; next cycle FLUSH masks hazard; perf_stalls unchanged.
//  5. rst asserted asynchronously mid-STALL (stall_cnt=2):
//     outputs return to reset values before the next edge; issue_instr=NOP_INSTR.
//  6. Force perf_stalls to 16'hFFFE, then 3 stall cycles: counter reads 16'hFFFF and holds.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the IF/ID/EX stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned InstrW = 16;
  localparam int unsigned CntW   = 2;

  localparam logic [InstrW-1:0] NopInstrDefault = 16'h0000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } sc_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Front-end control bundle between the ID stage / hazard detector and the stall sequencer.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  import pipeline_stall_ctrl_pkg::*;

  logic [InstrW-1:0] id_instr;
  logic              id_valid;
  logic              hazard;
  logic              br_flush;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [InstrW-1:0] issue_instr;
  logic [CntW-1:0]   stall_cnt;
  logic              stall_err;
  logic [PERF_W-1:0] perf_stalls;

  modport master (
    output id_instr, id_valid, hazard, br_flush,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, issue_instr, stall_cnt, stall_err,
           perf_stalls
  );

  modport slave (
    input  id_instr, id_valid, hazard, br_flush,
    output pc_we, ifid_we, ifid_flush, idex_bubble, issue_instr, stall_cnt, stall_err,
           perf_stalls
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [PERF_W-1:0] q
);

  logic [PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {PERF_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX front end; bubbles ID/EX while a RAW hazard persists
// and publishes the instruction actually issued to EX.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned       DEPTH     = 3,
  parameter logic [InstrW-1:0] NOP_INSTR = NopInstrDefault,
  parameter int unsigned       PERF_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  sc_state_e         state_q, state_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;
  logic [InstrW-1:0] issue_q, issue_d;
  logic              stall_go, force_rel;
  logic              pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [PERF_W-1:0] perf_q;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      issue_q     <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      issue_q     <= issue_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q | force_rel;
    issue_d     = (idex_bubble || !bus.id_valid) ? NOP_INSTR : bus.id_instr;
    if (bus.br_flush) begin
      state_d     = StFlush;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stall_go) begin
            state_d     = StStall;
            stall_cnt_d = CntW'(1);
          end
        end
        StStall: begin
          if (stall_go) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end else begin
            state_d     = StRun;
            stall_cnt_d = '0;
          end
        end
        StFlush: state_d = StRun;
        default: begin
          state_d     = StRun;
          stall_cnt_d = '0;
        end
      endcase
    end
  end

  // Mealy control outputs; flush wins over hazard, and FLUSH masks hazard entirely
  always_comb begin
    stall_go    = 1'b0;
    force_rel   = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (bus.br_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun:   stall_go = bus.hazard && bus.id_valid;
        StStall: begin
          stall_go  = bus.hazard && (stall_cnt_q < DepthCnt);
          force_rel = bus.hazard && (stall_cnt_q >= DepthCnt);
        end
        default: stall_go = 1'b0;
      endcase
      if (stall_go) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  sat_counter #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (stall_go),
    .clr (1'b0),
    .q   (perf_q)
  );

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.issue_instr = issue_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.stall_err   = stall_err_q;
  assign bus.perf_stalls = perf_q;

endmodule
